mont_mult_param: RTL and testbench

- Parametrised radix-2 bit-serial Montgomery multiplier. Computes result = (a * b * 2^-len) mod m.
- Successor to the fixed 32-bit multiplier. Adds the following:
  - WIDTH parameter.
  - One full iteration per clock.
  - Operand latching.
  - start/busy/done handshake with a single-cycle done pulse.
  - Argument error detection.
- Building block for the modular-exponentiation controller.

---
 rtl/mont_mult_param.sv | 192 +++++++++++++++++++
 tb/tb_mont_mult_param.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/mont_mult_param.sv
// mont_mult_param: radix-2 bit-serial Montgomery multiplier.
//
// Computes o_result = (a * b * 2^-len) mod m. One iteration is done per clock, so a
// legal request takes len+1 cycles from acceptance to the done pulse.
//
// Parameters:
//   WIDTH  operand/modulus width in bits
//   LEN_W  width of i_len; 2^LEN_W must exceed WIDTH
//
// Ports:
//   i_clk     clock, rising edge
//   i_rst     synchronous active-high reset; aborts any running computation
//   i_start   request, only sampled while idle
//   i_len     iteration count (R = 2^len), legal range 1..WIDTH
//   i_a, i_b  operands, expected < m (not checked)
//   i_m       modulus, must be odd
//   o_busy    high while a computation is in progress
//   o_done    one-cycle pulse when o_result/o_err are valid
//   o_err     qualified by o_done; 1 = illegal arguments were presented
//   o_result  Montgomery product, held until the next done pulse

module mont_mult_param #(
  parameter int WIDTH = 32,
  parameter int LEN_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [LEN_W-1:0] i_len,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [WIDTH-1:0] i_m,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_err,
  output logic [WIDTH-1:0] o_result
);

  // Accumulator carries two guard bits: with acc < 2^(W+1) and b, m < 2^W the
  // pre-shift sum acc + b + m stays below 2^(W+2), even for unchecked a/b >= m.
  localparam int AccW = WIDTH + 2;

  localparam logic [LEN_W-1:0] LenMax = LEN_W'(WIDTH);
  localparam logic [LEN_W-1:0] LenOne = LEN_W'(1);

  typedef enum logic [1:0] {
    StIdle,
    StIter,
    StFix
  } state_e;

  state_e           r_state;
  state_e           w_state_d;

  // Latched operands. r_a is shifted right each iteration so bit 0 is always a[i].
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] w_a_d;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] w_b_d;
  logic [WIDTH-1:0] r_m;
  logic [WIDTH-1:0] w_m_d;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] w_len_d;

  logic [LEN_W-1:0] r_idx;
  logic [LEN_W-1:0] w_idx_d;
  logic [AccW-1:0]  r_acc;
  logic [AccW-1:0]  w_acc_d;

  logic             r_done;
  logic             w_done_d;
  logic             r_err;
  logic             w_err_d;
  logic [WIDTH-1:0] r_result;
  logic [WIDTH-1:0] w_result_d;

  // Datapath
  logic             w_args_ok;
  logic [AccW-1:0]  w_b_ext;
  logic [AccW-1:0]  w_m_ext;
  logic [AccW-1:0]  w_t;
  logic [AccW-1:0]  w_tq;
  logic [AccW-1:0]  w_acc_next;
  logic             w_last;
  logic             w_ge_m;
  logic [WIDTH-1:0] w_fix;

  assign w_args_ok = i_m[0] && (i_len != '0) && (i_len <= LenMax);

  assign w_b_ext = {2'b00, r_b};
  assign w_m_ext = {2'b00, r_m};

  // t = acc + a[i]*b ; q = t[0] ; acc' = (t + q*m) / 2
  assign w_t        = r_acc + (r_a[0] ? w_b_ext : '0);
  assign w_tq       = w_t + (w_t[0] ? w_m_ext : '0);
  assign w_acc_next = w_tq >> 1;

  assign w_last = (r_idx == (r_len - LenOne));

  // Final conditional subtraction; only the low WIDTH bits are kept, so the
  // subtraction itself can be done at WIDTH bits.
  assign w_ge_m = (r_acc >= w_m_ext);
  assign w_fix  = r_acc[WIDTH-1:0] - (w_ge_m ? r_m : '0);

  // Next-state and next-value logic
  always_comb begin
    w_state_d  = r_state;
    w_a_d      = r_a;
    w_b_d      = r_b;
    w_m_d      = r_m;
    w_len_d    = r_len;
    w_idx_d    = r_idx;
    w_acc_d    = r_acc;
    w_done_d   = 1'b0;
    w_err_d    = r_err;
    w_result_d = r_result;

    unique case (r_state)
      StIdle: begin
        if (i_start) begin
          if (w_args_ok) begin
            w_a_d     = i_a;
            w_b_d     = i_b;
            w_m_d     = i_m;
            w_len_d   = i_len;
            w_acc_d   = '0;
            w_idx_d   = '0;
            w_state_d = StIter;
          end else begin
            // Reject immediately: error response on the following cycle.
            w_done_d   = 1'b1;
            w_err_d    = 1'b1;
            w_result_d = '0;
          end
        end
      end

      StIter: begin
        w_acc_d = w_acc_next;
        w_a_d   = r_a >> 1;
        w_idx_d = r_idx + LenOne;
        if (w_last) begin
          w_state_d = StFix;
        end
      end

      StFix: begin
        w_result_d = w_fix;
        w_done_d   = 1'b1;
        w_err_d    = 1'b0;
        w_state_d  = StIdle;
      end

      default: begin
        w_state_d = StIdle;
      end
    endcase
  end

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= StIdle;
      r_a      <= '0;
      r_b      <= '0;
      r_m      <= '0;
      r_len    <= '0;
      r_idx    <= '0;
      r_acc    <= '0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_result <= '0;
    end else begin
      r_state  <= w_state_d;
      r_a      <= w_a_d;
      r_b      <= w_b_d;
      r_m      <= w_m_d;
      r_len    <= w_len_d;
      r_idx    <= w_idx_d;
      r_acc    <= w_acc_d;
      r_done   <= w_done_d;
      r_err    <= w_err_d;
      r_result <= w_result_d;
    end
  end

  assign o_busy   = (r_state != StIdle);
  assign o_done   = r_done;
  assign o_err    = r_err;
  assign o_result = r_result;

endmodule

// File: tb/tb_mont_mult_param.sv
// Testbench for mont_mult_param (WIDTH=8). A vector table drives single requests;
// expected {result, err, done-cycle} records are queued when a request is driven
// and popped by a monitor whenever the DUT pulses done. Hand-written sequences
// cover start-while-busy, back-to-back start and reset mid-operation.

module tb_mont_mult_param;

  localparam int WIDTH = 8;
  localparam int LEN_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [LEN_W-1:0] len;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] m;
  logic             busy;
  logic             done;
  logic             err;
  logic [WIDTH-1:0] result;

  mont_mult_param #(
    .WIDTH(WIDTH),
    .LEN_W(LEN_W)
  ) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_start (start),
    .i_len   (len),
    .i_a     (a),
    .i_b     (b),
    .i_m     (m),
    .o_busy  (busy),
    .o_done  (done),
    .o_err   (err),
    .o_result(result)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] len;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] m;
    logic [7:0] res;
    logic       err;
  } vec_t;

  typedef struct {
    int res;
    int err;
    int due;
  } exp_t;

  vec_t vecs[9];
  exp_t sb[$];

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input int got, input int expv);
    n_vec++;
    if (got != expv) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, got, expv, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (done) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_done: got done=1, required done=0 (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("result", int'(result), e.res);
        check("err", int'(err), e.err);
        check("done_cycle", cyc, e.due);
      end
    end
  end

  // Called at a negedge; the next posedge samples start.
  task automatic drive(input logic [7:0] l, input logic [7:0] av, input logic [7:0] bv,
                       input logic [7:0] mv);
    len   = l;
    a     = av;
    b     = bv;
    m     = mv;
    start = 1'b1;
  endtask

  task automatic push_exp(input int res, input int e, input int lat);
    exp_t x;
    x.res = res;
    x.err = e;
    x.due = cyc + 1 + lat;
    sb.push_back(x);
  endtask

  task automatic drain();
    for (int k = 0; k < 40 && sb.size() != 0; k++) @(negedge clk);
    check("drain_pending", sb.size(), 0);
    sb.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    logic legal;

    vecs[0] = '{len: 8'd4, a: 8'd7,   b: 8'd5,   m: 8'd13,  res: 8'd3,   err: 1'b0};
    vecs[1] = '{len: 8'd4, a: 8'd11,  b: 8'd12,  m: 8'd13,  res: 8'd5,   err: 1'b0};
    vecs[2] = '{len: 8'd8, a: 8'd1,   b: 8'd1,   m: 8'd251, res: 8'd201, err: 1'b0};
    vecs[3] = '{len: 8'd8, a: 8'd100, b: 8'd200, m: 8'd251, res: 8'd235, err: 1'b0};
    vecs[4] = '{len: 8'd1, a: 8'd1,   b: 8'd4,   m: 8'd13,  res: 8'd2,   err: 1'b0};
    vecs[5] = '{len: 8'd8, a: 8'd254, b: 8'd254, m: 8'd255, res: 8'd1,   err: 1'b0};
    vecs[6] = '{len: 8'd4, a: 8'd7,   b: 8'd5,   m: 8'd12,  res: 8'd0,   err: 1'b1};
    vecs[7] = '{len: 8'd0, a: 8'd7,   b: 8'd5,   m: 8'd13,  res: 8'd0,   err: 1'b1};
    vecs[8] = '{len: 8'd9, a: 8'd7,   b: 8'd5,   m: 8'd13,  res: 8'd0,   err: 1'b1};

    rst   = 1'b1;
    start = 1'b0;
    len   = '0;
    a     = '0;
    b     = '0;
    m     = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_err", int'(err), 0);
    check("reset_result", int'(result), 0);
    rst = 1'b0;
    @(negedge clk);

    // Table-driven single requests
    for (int i = 0; i < 9; i++) begin
      legal = !vecs[i].err;
      push_exp(int'(vecs[i].res), int'(vecs[i].err), legal ? int'(vecs[i].len) + 1 : 0);
      drive(vecs[i].len, vecs[i].a, vecs[i].b, vecs[i].m);
      @(negedge clk);
      start = 1'b0;
      check("busy_after_start", int'(busy), legal ? 1 : 0);
      // Operands must already be latched.
      a = 8'($urandom);
      b = 8'($urandom);
      m = 8'($urandom);
      len = 8'($urandom);
      drain();
      check("idle_after_done", int'(busy), 0);
      @(negedge clk);
    end

    // Start while busy is ignored; start in the done cycle is accepted.
    push_exp(3, 0, 5);
    drive(8'd4, 8'd7, 8'd5, 8'd13);
    t0 = cyc + 1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    drive(8'd4, 8'd1, 8'd1, 8'd13);
    @(negedge clk);
    start = 1'b0;
    while (cyc < t0 + 5) @(negedge clk);
    check("seq_done_cycle", int'(done), 1);
    push_exp(5, 0, 5);
    drive(8'd4, 8'd11, 8'd12, 8'd13);
    @(negedge clk);
    start = 1'b0;
    check("b2b_busy", int'(busy), 1);
    drain();

    // Reset mid-operation aborts with no done pulse.
    @(negedge clk);
    drive(8'd4, 8'd7, 8'd5, 8'd13);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", int'(busy), 0);
    check("abort_result", int'(result), 0);
    check("abort_done", int'(done), 0);
    repeat (8) @(negedge clk);
    push_exp(3, 0, 5);
    drive(8'd4, 8'd7, 8'd5, 8'd13);
    @(negedge clk);
    start = 1'b0;
    drain();
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
